vga_sync_receiver: RTL
======================

# vga_sync_receiver

Receive end of the VGA video path: samples the H_SYNC/V_SYNC/R/G/B stream produced by the pixel generator and recovers the pixel position of every sample. It checks line and frame timing against the 640x480@60 parameters, reports lock and timing errors, and emits visible pixels with their coordinates. It is used in loopback self-checking of the generator and as the front end of a frame-capture path.

## Interface
- H_SYNC_W, 96: hsync pulse width, pixels
- H_BACK, 48: h back porch
- H_VISIBLE, 640: visible pixels per line
- H_TOTAL, 800: pixels per line
- V_SYNC_W, 2: vsync pulse width, lines
- V_BACK, 33: v back porch
- V_VISIBLE, 480: visible lines
- V_TOTAL, 525: lines per frame
- CLK_IN  in  1  pixel clock; one pixel per rising edge
- RST_N  in  1  asynchronous, active-low reset
- H_SYNC  in  1  horizontal sync, active low, synchronous to CLK_IN
- V_SYNC  in  1  vertical sync, active low
- R, G, B  in  1 each  pixel colour
- PIX_VALID  out  1  PIX_* hold a visible pixel (LOCKED only)
- PIX_X  out  10  visible column, 0..H_VISIBLE-1
- PIX_Y  out  10  visible row, 0..V_VISIBLE-1
- PIX_RGB  out  3  {R,G,B} of that pixel
- FRAME_START  out  1  one-cycle pulse on each frame restart
- LOCKED  out  1  timing verified for one full frame, no error since
- LINE_ERR  out  1  one-cycle pulse, horizontal timing violation
- FRAME_ERR  out  1  one-cycle pulse, vertical timing violation

## Operation
- Input stage S1 registers H_SYNC, V_SYNC, R, G, B every edge. S2 holds the previous S1 syncs. S1/S2 sync regs reset to 1 (inactive) so reset release creates no false edge.
- hs_fall = S2.hs & ~S1.hs. hs_rise = ~S2.hs & S1.hs. vs_fall is analogous.
- h_pos (11 bit): set to 0 on hs_fall, else +1, saturating at 2047.
- vs_fall sets v_pend. Frame restart = hs_fall while v_pend, or while vs_fall in the same cycle. On restart: v_pos←0, v_pend←0, FRAME_START pulse (in every state). On any other hs_fall: v_pos+1, saturating at 1023.
- States:
  - SEARCH: no checks. A restart moves to ACQUIRE.
  - ACQUIRE: checks active. An error moves to SEARCH. A restart with no error moves to LOCKED.
  - LOCKED: checks active. An error moves to SEARCH.
- LINE_ERR, checked in ACQUIRE/LOCKED only:
  - hs_fall with h_pos ≠ H_TOTAL-1.
  - hs_rise with h_pos ≠ H_SYNC_W-1.
  - h_pos reaching H_TOTAL with no hs_fall; pulses once per line.
- FRAME_ERR, checked in ACQUIRE/LOCKED only:
  - restart with v_pos ≠ V_TOTAL-1.
  - v_pos reaching V_TOTAL on an hs_fall that is not a restart.
- LINE_ERR and FRAME_ERR in the same cycle: both pulse, a single transition to SEARCH.
- Visible window:
  - h_pos in [H_SYNC_W+H_BACK, +H_VISIBLE) = [144,784).
  - v_pos in [V_SYNC_W+V_BACK, +V_VISIBLE) = [35,515).
  - PIX_X = h_pos-144, PIX_Y = v_pos-35, truncated to 10 bits.
- PIX_VALID = LOCKED-state & in window. PIX_X/Y/RGB update every cycle; they are meaningful only with PIX_VALID.

## Timing
- Reset: state SEARCH, h_pos=v_pos=0, v_pend=0, all outputs 0.
- Reset mid-frame clears everything immediately (asynchronous). Relock needs two frame restarts.
- Latency: input sampled at edge n, decision from S1/S2, outputs registered at edge n+1. All outputs are mutually aligned.
- State change and LOCKED update land on the same edge as the causing pulse. LOCKED rises together with the second FRAME_START after reset under nominal input.
- LOCKED falls together with the error pulse; PIX_VALID is 0 from that edge on.

## Test plan
- Nominal stream (generator model, 800x525, R=x[0], G=y[0], B=1) for 3 frames → LOCKED rises with the 2nd FRAME_START; the first valid pixel has X=0, Y=0, RGB=3'b001, 2 edges after it is driven; 307200 PIX_VALID cycles per frame; no errors.
- Locked, then one line of 799 pixels → LINE_ERR pulse at the early hs_fall; LOCKED=0 on the same edge; relock after 2 restarts.
- Locked, then hsync suppressed for one line → single LINE_ERR when h_pos hits 800; LOCKED drops.
- Locked, then hsync width 95 → LINE_ERR at hs_rise.
- Locked, then a frame of 524 lines → FRAME_ERR on that restart, FRAME_START also pulses, LOCKED drops.
- RST_N low for 3 cycles mid-frame → all outputs 0 immediately; LOCKED=0 until the 2nd subsequent FRAME_START.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//
// Receive end of the VGA video path. Samples the sync/colour stream coming
// from the pixel generator, rebuilds the horizontal and vertical pixel
// position of every sample, checks line and frame timing, and hands out
// visible pixels together with their coordinates.
//
// Ports
//   CLK_IN       pixel clock, one pixel per rising edge
//   RST_N        asynchronous active-low reset
//   H_SYNC       horizontal sync, active low
//   V_SYNC       vertical sync, active low
//   R, G, B      pixel colour bits
//   PIX_VALID    PIX_X/PIX_Y/PIX_RGB carry a visible pixel (locked only)
//   PIX_X        visible column
//   PIX_Y        visible row
//   PIX_RGB      {R,G,B} of that pixel
//   FRAME_START  one-cycle pulse on every frame restart
//   LOCKED       a full frame has been verified and no error seen since
//   LINE_ERR     one-cycle pulse on a horizontal timing violation
//   FRAME_ERR    one-cycle pulse on a vertical timing violation
//
// All outputs are registered on the edge after the sample enters the input
// stage, so they stay mutually aligned.

module vga_sync_receiver #(
   parameter int H_SYNC_W  = 96,
   parameter int H_BACK    = 48,
   parameter int H_VISIBLE = 640,
   parameter int H_TOTAL   = 800,
   parameter int V_SYNC_W  = 2,
   parameter int V_BACK    = 33,
   parameter int V_VISIBLE = 480,
   parameter int V_TOTAL   = 525
) (
   input  logic       CLK_IN,
   input  logic       RST_N,
   input  logic       H_SYNC,
   input  logic       V_SYNC,
   input  logic       R,
   input  logic       G,
   input  logic       B,
   output logic       PIX_VALID,
   output logic [9:0] PIX_X,
   output logic [9:0] PIX_Y,
   output logic [2:0] PIX_RGB,
   output logic       FRAME_START,
   output logic       LOCKED,
   output logic       LINE_ERR,
   output logic       FRAME_ERR
);

   localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_SYNC_LAST = 11'(H_SYNC_W - 1);
   localparam logic [10:0] H_WIN_LO    = 11'(H_SYNC_W + H_BACK);
   localparam logic [10:0] H_WIN_HI    = 11'(H_SYNC_W + H_BACK + H_VISIBLE);
   localparam logic [10:0] H_MAX       = 11'h7FF;
   localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_WIN_LO    = 10'(V_SYNC_W + V_BACK);
   localparam logic [9:0]  V_WIN_HI    = 10'(V_SYNC_W + V_BACK + V_VISIBLE);
   localparam logic [9:0]  V_MAX       = 10'h3FF;

   typedef enum logic [1:0] {
      STATE_SEARCH,
      STATE_ACQUIRE,
      STATE_LOCKED
   } syncState_t;

   syncState_t  state;
   syncState_t  stateNext;

   logic        s1Hs;
   logic        s1Vs;
   logic        s1R;
   logic        s1G;
   logic        s1B;
   logic        s2Hs;
   logic        s2Vs;

   logic [10:0] hPos;
   logic [9:0]  vPos;
   logic        vPend;

   logic        hsFall;
   logic        hsRise;
   logic        vsFall;
   logic        restart;
   logic        checking;
   logic        lineErrNow;
   logic        frameErrNow;
   logic        inWindow;
   logic [10:0] hNext;
   logic [9:0]  vNext;

   // Input stage. S1 captures the raw pins every edge and S2 keeps the
   // previous sync values so edges can be detected. The sync registers come
   // out of reset high (inactive) so that releasing reset while the pins are
   // idle never looks like a falling edge.
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         s1Hs <= 1'b1;
         s1Vs <= 1'b1;
         s1R  <= 1'b0;
         s1G  <= 1'b0;
         s1B  <= 1'b0;
         s2Hs <= 1'b1;
         s2Vs <= 1'b1;
      end else begin
         s1Hs <= H_SYNC;
         s1Vs <= V_SYNC;
         s1R  <= R;
         s1G  <= G;
         s1B  <= B;
         s2Hs <= s1Hs;
         s2Vs <= s1Vs;
      end
   end

   // Edge detection and the position the sample now sitting in S1 will get.
   // hPos/vPos always describe the sample that has moved on to S2, so the
   // checks look at the current hPos/vPos (the line just finished) while the
   // pixel outputs use hNext/vNext (the sample being emitted). A frame
   // restart is the first hsync fall after a vsync fall, including the case
   // where both fall together.
   always_comb begin
      hsFall  = s2Hs & ~s1Hs;
      hsRise  = ~s2Hs & s1Hs;
      vsFall  = s2Vs & ~s1Vs;
      restart = hsFall & (vPend | vsFall);

      hNext = hPos;
      if (hsFall) begin
         hNext = 11'd0;
      end else if (hPos != H_MAX) begin
         hNext = hPos + 11'd1;
      end

      vNext = vPos;
      if (restart) begin
         vNext = 10'd0;
      end else if (hsFall && (vPos != V_MAX)) begin
         vNext = vPos + 10'd1;
      end

      inWindow = (hNext >= H_WIN_LO) && (hNext < H_WIN_HI) &&
                 (vNext >= V_WIN_LO) && (vNext < V_WIN_HI);
   end

   // Timing checks. Only armed once a restart has been seen. The missing
   // hsync check fires on the single step from the last legal position to
   // one past it, and hPos only passes that value once per line, so a long
   // gap reports exactly one error.
   always_comb begin
      checking = (state != STATE_SEARCH);

      lineErrNow = checking &&
                   ((hsFall && (hPos != H_LAST)) ||
                    (hsRise && (hPos != H_SYNC_LAST)) ||
                    (!hsFall && (hPos == H_LAST)));

      frameErrNow = checking &&
                    ((restart && (vPos != V_LAST)) ||
                     (hsFall && !restart && (vPos == V_LAST)));
   end

   // Lock state machine next state. Any error, line or frame, drops back to
   // searching; a clean restart promotes acquire to locked, so locking takes
   // two restarts from search.
   always_comb begin
      stateNext = state;
      case (state)
         STATE_SEARCH: begin
            if (restart) begin
               stateNext = STATE_ACQUIRE;
            end
         end
         STATE_ACQUIRE: begin
            if (lineErrNow || frameErrNow) begin
               stateNext = STATE_SEARCH;
            end else if (restart) begin
               stateNext = STATE_LOCKED;
            end
         end
         STATE_LOCKED: begin
            if (lineErrNow || frameErrNow) begin
               stateNext = STATE_SEARCH;
            end
         end
         default: begin
            stateNext = STATE_SEARCH;
         end
      endcase
   end

   // Position counters, state register and all registered outputs. LOCKED
   // and PIX_VALID follow the next state so that they change on the same
   // edge as the pulse that caused the transition.
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         state       <= STATE_SEARCH;
         hPos        <= 11'd0;
         vPos        <= 10'd0;
         vPend       <= 1'b0;
         PIX_VALID   <= 1'b0;
         PIX_X       <= 10'd0;
         PIX_Y       <= 10'd0;
         PIX_RGB     <= 3'd0;
         FRAME_START <= 1'b0;
         LOCKED      <= 1'b0;
         LINE_ERR    <= 1'b0;
         FRAME_ERR   <= 1'b0;
      end else begin
         state <= stateNext;
         hPos  <= hNext;
         vPos  <= vNext;
         if (restart) begin
            vPend <= 1'b0;
         end else if (vsFall) begin
            vPend <= 1'b1;
         end
         FRAME_START <= restart;
         LINE_ERR    <= lineErrNow;
         FRAME_ERR   <= frameErrNow;
         LOCKED      <= (stateNext == STATE_LOCKED);
         PIX_VALID   <= (stateNext == STATE_LOCKED) && inWindow;
         PIX_X       <= 10'(hNext - H_WIN_LO);
         PIX_Y       <= vNext - V_WIN_LO;
         PIX_RGB     <= {s1R, s1G, s1B};
      end
   end

endmodule
